// File: rtl/fm_eg_pkg.sv
// Shared widths, stage/FSM encodings and small helpers for the FM operator
// envelope generator.
package fm_eg_pkg;

    localparam int unsigned EG_CNT_W   = 15;
    localparam int unsigned ENV_W      = 9;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned INIT_SLOTS = 64;

    localparam logic [ENV_W-1:0] ENV_MAX = 9'd511;

    typedef enum logic [1:0] {
        EG_ATTACK  = 2'd0,
        EG_DECAY   = 2'd1,
        EG_SUSTAIN = 2'd2,
        EG_RELEASE = 2'd3
    } eg_stage_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2
    } eg_fsm_e;

    function automatic logic [ENV_W-1:0] env_inc_sat(input logic [ENV_W-1:0] env);
        return (env == ENV_MAX) ? ENV_MAX : env + 1'b1;
    endfunction

endpackage

// File: rtl/fm_eg_rate.sv
// Rate counter advance: adds 2^(rate-1) to the envelope counter and reports
// the carry out of the 15-bit counter, which is the envelope step strobe.
module fm_eg_rate
    import fm_eg_pkg::*;
(
    input  logic [3:0]          rate,
    input  logic [EG_CNT_W-1:0] cnt,
    output logic [EG_CNT_W-1:0] cnt_next,
    output logic                carry
);

    logic [EG_CNT_W:0] step;
    logic [EG_CNT_W:0] sum;

    always_comb begin
        step = '0;
        if (rate != 4'd0) begin
            step = {{EG_CNT_W{1'b0}}, 1'b1} << (rate - 4'd1);
        end
        sum      = {1'b0, cnt} + step;
        cnt_next = sum[EG_CNT_W-1:0];
        carry    = sum[EG_CNT_W];
    end

endmodule

// File: rtl/fm_op_eg.sv
// Time-multiplexed envelope generator: sweeps all operator slots once per
// sample tick, read-modify-writing each slot's EG state in a single cycle.
module fm_op_eg
    import fm_eg_pkg::*;
#(
    parameter int unsigned NUM_OPS = 36
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic [IDX_W-1:0]    o_idx,
    output logic                o_wren,
    output logic [1:0]          o_eg_stage,
    output logic [EG_CNT_W-1:0] o_eg_cnt,
    output logic [ENV_W-1:0]    o_eg_env,
    input  logic [1:0]          i_eg_stage,
    input  logic [EG_CNT_W-1:0] i_eg_cnt,
    input  logic [ENV_W-1:0]    i_eg_env,
    input  logic                i_key_on,
    input  logic [3:0]          i_ar,
    input  logic [3:0]          i_dr,
    input  logic [3:0]          i_rr,
    input  logic [3:0]          i_sl,
    output logic [ENV_W-1:0]    o_env,
    output logic [IDX_W-1:0]    o_env_idx,
    output logic                o_env_valid
);

    localparam logic [IDX_W-1:0] LAST_RUN_IDX  = IDX_W'(NUM_OPS - 1);
    localparam logic [IDX_W-1:0] LAST_INIT_IDX = IDX_W'(INIT_SLOTS - 1);

    eg_fsm_e             state;
    eg_stage_e           cur_stage;
    eg_stage_e           nxt_stage;
    logic [EG_CNT_W-1:0] nxt_cnt;
    logic [ENV_W-1:0]    nxt_env;
    logic [ENV_W-1:0]    atk_dec;
    logic [ENV_W-1:0]    atk_env;
    logic [3:0]          rate;
    logic [EG_CNT_W-1:0] adv_cnt;
    logic                adv_carry;

    assign cur_stage = eg_stage_e'(i_eg_stage);
    assign o_busy    = (state != ST_IDLE);

    // INIT spends its first cycle raising o_wren so reset itself holds o_wren low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_INIT;
            o_idx  <= '0;
            o_wren <= 1'b0;
            o_done <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (!o_wren) begin
                        o_wren <= 1'b1;
                    end else if (o_idx == LAST_INIT_IDX) begin
                        state  <= ST_IDLE;
                        o_wren <= 1'b0;
                        o_idx  <= '0;
                    end else begin
                        o_idx <= o_idx + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (i_start) begin
                        state  <= ST_RUN;
                        o_wren <= 1'b1;
                        o_idx  <= '0;
                    end
                end
                ST_RUN: begin
                    if (o_idx == LAST_RUN_IDX) begin
                        state  <= ST_IDLE;
                        o_wren <= 1'b0;
                        o_idx  <= '0;
                        o_done <= 1'b1;
                    end else begin
                        o_idx <= o_idx + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_INIT;
                    o_wren <= 1'b0;
                    o_idx  <= '0;
                end
            endcase
        end
    end

    always_comb begin
        case (cur_stage)
            EG_ATTACK:  rate = i_ar;
            EG_DECAY:   rate = i_dr;
            EG_RELEASE: rate = i_rr;
            default:    rate = 4'd0;
        endcase
    end

    fm_eg_rate u_rate (
        .rate     (rate),
        .cnt      (i_eg_cnt),
        .cnt_next (adv_cnt),
        .carry    (adv_carry)
    );

    assign atk_dec = (i_eg_env >> 3) + 1'b1;
    assign atk_env = (i_eg_env <= atk_dec) ? '0 : i_eg_env - atk_dec;

    always_comb begin
        nxt_stage = cur_stage;
        nxt_cnt   = i_eg_cnt;
        nxt_env   = i_eg_env;
        if (!i_key_on && cur_stage != EG_RELEASE) begin
            nxt_stage = EG_RELEASE;
            nxt_cnt   = '0;
        end else if (i_key_on && cur_stage == EG_RELEASE) begin
            nxt_stage = EG_ATTACK;
            nxt_cnt   = '0;
        end else begin
            case (cur_stage)
                EG_ATTACK: begin
                    nxt_cnt = adv_cnt;
                    if (adv_carry) nxt_env = atk_env;
                    if (nxt_env == '0) nxt_stage = EG_DECAY;
                end
                EG_DECAY: begin
                    nxt_cnt = adv_cnt;
                    if (adv_carry) nxt_env = env_inc_sat(i_eg_env);
                    if (nxt_env >= {i_sl, 5'b0}) nxt_stage = EG_SUSTAIN;
                end
                EG_RELEASE: begin
                    nxt_cnt = adv_cnt;
                    if (adv_carry) nxt_env = env_inc_sat(i_eg_env);
                end
                default: begin
                    nxt_stage = cur_stage;
                end
            endcase
        end
    end

    always_comb begin
        if (state == ST_INIT) begin
            o_eg_stage = EG_RELEASE;
            o_eg_cnt   = '0;
            o_eg_env   = ENV_MAX;
        end else begin
            o_eg_stage = nxt_stage;
            o_eg_cnt   = nxt_cnt;
            o_eg_env   = nxt_env;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_env       <= ENV_MAX;
            o_env_idx   <= '0;
            o_env_valid <= 1'b0;
        end else begin
            o_env_valid <= (state == ST_RUN);
            if (state == ST_RUN) begin
                o_env     <= nxt_env;
                o_env_idx <= o_idx;
            end
        end
    end

endmodule

// File: tb/tb_fm_op_eg.sv
// Self-checking bench for fm_op_eg: models the EG state RAM and parameter file,
// and predicts each slot update with a behavioural envelope model.
module tb_fm_op_eg;

    localparam int NOPS = 36;

    typedef struct {
        int st;
        int cnt;
        int env;
    } egs_t;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic        o_busy, o_done, o_wren, o_env_valid;
    logic [5:0]  o_idx, o_env_idx;
    logic [1:0]  o_eg_stage, i_eg_stage;
    logic [14:0] o_eg_cnt, i_eg_cnt;
    logic [8:0]  o_eg_env, i_eg_env, o_env;
    logic        i_key_on;
    logic [3:0]  i_ar, i_dr, i_rr, i_sl;

    logic [1:0]  ram_st [64];
    logic [14:0] ram_cnt[64];
    logic [8:0]  ram_env[64];
    logic        key[64];
    logic [3:0]  ar[64], dr[64], rr[64], sl[64];
    egs_t        mdl[64];

    int total = 0;
    int bad   = 0;

    assign i_eg_stage = ram_st[o_idx];
    assign i_eg_cnt   = ram_cnt[o_idx];
    assign i_eg_env   = ram_env[o_idx];
    assign i_key_on   = key[o_idx];
    assign i_ar       = ar[o_idx];
    assign i_dr       = dr[o_idx];
    assign i_rr       = rr[o_idx];
    assign i_sl       = sl[o_idx];

    fm_op_eg #(.NUM_OPS(NOPS)) dut (
        .clk(clk), .reset(reset), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done), .o_idx(o_idx), .o_wren(o_wren),
        .o_eg_stage(o_eg_stage), .o_eg_cnt(o_eg_cnt), .o_eg_env(o_eg_env),
        .i_eg_stage(i_eg_stage), .i_eg_cnt(i_eg_cnt), .i_eg_env(i_eg_env),
        .i_key_on(i_key_on), .i_ar(i_ar), .i_dr(i_dr), .i_rr(i_rr), .i_sl(i_sl),
        .o_env(o_env), .o_env_idx(o_env_idx), .o_env_valid(o_env_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Envelope rules in plain integer arithmetic: 0=attack 1=decay 2=sustain 3=release
    function automatic egs_t eg_next(egs_t s, int k, int a, int d, int r, int l);
        egs_t n;
        int rate, step, sum;
        bit carry;
        n = s;
        if (k == 0 && s.st != 3) begin
            n.st = 3; n.cnt = 0;
        end else if (k == 1 && s.st == 3) begin
            n.st = 0; n.cnt = 0;
        end else if (s.st != 2) begin
            rate  = (s.st == 0) ? a : (s.st == 1) ? d : r;
            step  = (rate == 0) ? 0 : 2 ** (rate - 1);
            sum   = s.cnt + step;
            carry = (sum >= 32768);
            n.cnt = sum % 32768;
            if (s.st == 0) begin
                if (carry) n.env = (s.env - (s.env / 8 + 1) < 0) ? 0 : s.env - (s.env / 8 + 1);
                if (n.env == 0) n.st = 1;
            end else if (s.st == 1) begin
                if (carry) n.env = (s.env + 1 > 511) ? 511 : s.env + 1;
                if (n.env >= l * 32) n.st = 2;
            end else begin
                if (carry) n.env = (s.env + 1 > 511) ? 511 : s.env + 1;
            end
        end
        return n;
    endfunction

    task automatic preload(input int slot, input int st, input int cnt, input int env);
        ram_st[slot]  = 2'(st);
        ram_cnt[slot] = 15'(cnt);
        ram_env[slot] = 9'(env);
        mdl[slot]     = '{st, cnt, env};
    endtask

    task automatic sweep(input bit poke_start);
        egs_t nx;
        int prev_env;
        logic [1:0]  wst;
        logic [14:0] wcnt;
        logic [8:0]  wenv;
        prev_env = 0;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int k = 0; k < NOPS; k++) begin
            @(negedge clk);
            nx = eg_next(mdl[k], int'(key[k]), int'(ar[k]), int'(dr[k]), int'(rr[k]), int'(sl[k]));
            chk("run_wren", o_wren, 1);
            chk("run_idx", o_idx, k);
            chk("run_busy", o_busy, 1);
            chk("run_done", o_done, 0);
            chk("wr_stage", o_eg_stage, nx.st);
            chk("wr_cnt", o_eg_cnt, nx.cnt);
            chk("wr_env", o_eg_env, nx.env);
            if (k == 0) begin
                chk("fwd_valid_first", o_env_valid, 0);
            end else begin
                chk("fwd_valid", o_env_valid, 1);
                chk("fwd_idx", o_env_idx, k - 1);
                chk("fwd_env", o_env, prev_env);
            end
            if (poke_start && k == 5) i_start = 1'b1;
            if (k == 7) i_start = 1'b0;
            wst = o_eg_stage; wcnt = o_eg_cnt; wenv = o_eg_env;
            @(posedge clk); #1;
            ram_st[k] = wst; ram_cnt[k] = wcnt; ram_env[k] = wenv;
            mdl[k] = nx;
            prev_env = nx.env;
        end
        @(negedge clk);
        chk("end_done", o_done, 1);
        chk("end_busy", o_busy, 0);
        chk("end_wren", o_wren, 0);
        chk("end_valid", o_env_valid, 1);
        chk("end_fwd_idx", o_env_idx, NOPS - 1);
        chk("end_fwd_env", o_env, prev_env);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_done", o_done, 0);
        chk("post_valid", o_env_valid, 0);
        chk("post_busy", o_busy, 0);
        if (poke_start) begin
            repeat (3) begin
                @(negedge clk);
                chk("no_extra_sweep", o_busy, 0);
                chk("no_extra_wren", o_wren, 0);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int w, dones, decay_at;
        bit seen;
        reset = 1'b1;
        i_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ram_st[i] = 2'($urandom); ram_cnt[i] = 15'($urandom); ram_env[i] = 9'($urandom);
            key[i] = 1'b0; ar[i] = '0; dr[i] = '0; rr[i] = '0; sl[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_wren", o_wren, 0);
        chk("rst_done", o_done, 0);
        chk("rst_valid", o_env_valid, 0);
        chk("rst_env", o_env, 511);
        chk("rst_env_idx", o_env_idx, 0);
        chk("rst_idx", o_idx, 0);
        chk("rst_busy", o_busy, 1);
        reset = 1'b0;

        // INIT: 64 writes of {RELEASE, 0, 511}
        w = 0;
        @(negedge clk);
        while (!o_wren && w < 4) begin
            w++;
            @(negedge clk);
        end
        chk("init_start", o_wren, 1);
        for (int i = 0; i < 64; i++) begin
            logic [1:0] s; logic [14:0] c; logic [8:0] e;
            if (i > 0) @(negedge clk);
            chk("init_idx", o_idx, i);
            chk("init_wren", o_wren, 1);
            chk("init_stage", o_eg_stage, 3);
            chk("init_cnt", o_eg_cnt, 0);
            chk("init_env", o_eg_env, 511);
            chk("init_valid", o_env_valid, 0);
            chk("init_done", o_done, 0);
            s = o_eg_stage; c = o_eg_cnt; e = o_eg_env;
            @(posedge clk); #1;
            if (o_wren || i == 63) begin
                ram_st[i] = s; ram_cnt[i] = c; ram_env[i] = e;
            end
        end
        @(negedge clk);
        chk("init_end_busy", o_busy, 0);
        chk("init_end_wren", o_wren, 0);
        chk("init_end_done", o_done, 0);
        @(posedge clk); #1;
        w = 0;
        for (int i = 0; i < 64; i++) if (ram_env[i] == 9'd511 && ram_st[i] == 2'd3) w++;
        chk("init_ram_all_511", w, 64);
        for (int i = 0; i < 64; i++) mdl[i] = '{3, 0, 511};

        // Directed slots
        key[0] = 1; ar[0] = 15; dr[0] = 0; sl[0] = 15;
        preload(3, 0, 1234, 300); key[3] = 1; ar[3] = 0;
        preload(5, 1, 0, 60);     key[5] = 1; dr[5] = 15; sl[5] = 2;
        preload(7, 2, 777, 500);  key[7] = 0; rr[7] = 15;
        preload(8, 1, 5, 100);    key[8] = 1; dr[8] = 3; sl[8] = 0;
        for (int i = 10; i < NOPS; i++)
            preload(i, int'($urandom_range(0, 3)), int'($urandom_range(0, 32767)), int'($urandom_range(0, 511)));

        decay_at = -1;
        for (int s = 0; s < 110; s++) begin
            for (int i = 10; i < NOPS; i++) begin
                key[i] = ($urandom_range(0, 3) != 0);
                ar[i] = 4'($urandom); dr[i] = 4'($urandom);
                rr[i] = 4'($urandom); sl[i] = 4'($urandom);
            end
            sweep(s == 2);
            if (s == 0) begin
                chk("s0_atk_stage", ram_st[0], 0);
                chk("s0_atk_cnt", ram_cnt[0], 0);
                chk("s0_atk_env", ram_env[0], 511);
                chk("s7_keyoff_stage", ram_st[7], 3);
                chk("s7_keyoff_cnt", ram_cnt[7], 0);
                chk("s7_keyoff_env", ram_env[7], 500);
                chk("s8_sl0_sustain", ram_st[8], 2);
            end
            if (decay_at < 0 && ram_st[0] == 2'd1) decay_at = s;
            if (s == 60) chk("s7_rel_sat_mid", ram_env[7], 511);
        end
        chk("s0_reached_decay", (decay_at > 0 && decay_at < 110), 1);
        chk("s0_env_zero", ram_env[0], 0);
        chk("s3_rate0_stage", ram_st[3], 0);
        chk("s3_rate0_cnt", ram_cnt[3], 1234);
        chk("s3_rate0_env", ram_env[3], 300);
        chk("s5_sustain_stage", ram_st[5], 2);
        chk("s5_sustain_env", ram_env[5], 64);
        chk("s7_release_stage", ram_st[7], 3);
        chk("s7_release_env", ram_env[7], 511);

        // Reset in the middle of a sweep
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        w = 0;
        @(negedge clk);
        while (o_idx != 6'd10 && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk("abort_at_idx10", o_idx, 10);
        reset = 1'b1;
        #1;
        chk("abort_wren", o_wren, 0);
        chk("abort_idx", o_idx, 0);
        chk("abort_busy", o_busy, 1);
        chk("abort_valid", o_env_valid, 0);
        chk("abort_done", o_done, 0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        seen = 1'b0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (o_done) dones++;
            if (o_wren && !seen) begin
                seen = 1'b1;
                chk("reinit_first_idx", o_idx, 0);
                chk("reinit_first_env", o_eg_env, 511);
            end
        end
        chk("reinit_seen", seen, 1);
        chk("abort_no_done", dones, 0);
        chk("reinit_idle", o_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
